// File: rtl/mem_bank_pkg.sv
// Shared sizing constants and the default boot program image for mem_bank.
package mem_bank_pkg;

  localparam int ADDR_W   = 8;
  localparam int WORD_W   = 16;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int BOOT_LEN = 17;
  localparam int BOOT_AW  = $clog2(BOOT_LEN);

  // Program restored into words 0..BOOT_LEN-1 whenever reset is asserted.
  localparam logic [WORD_W-1:0] BOOT_IMAGE [0:BOOT_LEN-1] = '{
    16'h0008, 16'h7280, 16'h72C0, 16'h1100, 16'h1152, 16'h994A,
    16'h1902, 16'h0308, 16'h7380, 16'hBC82, 16'hCCC3, 16'hF004,
    16'h0C10, 16'hF009, 16'h0C18, 16'hF004, 16'h0001
  };

  // Reset value of word idx: boot image inside the image, zero beyond it.
  function automatic logic [WORD_W-1:0] boot_word(input int unsigned idx);
    logic [WORD_W-1:0] w_val;
    w_val = '0;
    if (idx < BOOT_LEN) begin
      w_val = BOOT_IMAGE[idx[BOOT_AW-1:0]];
    end
    return w_val;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Instruction memory bank: 256 x 16-bit words, synchronous fetch port with
// zero extension to 32 bits, synchronous load port, and an asynchronous
// reset that restores the boot program image.
module mem_bank
  import mem_bank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata
);

  // Flattened view of every stored word, used by the fetch mux.
  logic [DEPTH-1:0][WORD_W-1:0] w_words;
  // One-hot write strobe per word.
  logic [DEPTH-1:0]             w_wr_en;
  // Fetched word after zero extension.
  logic [DATA_W-1:0]            w_rd_ext;

  // The storage cannot be a block RAM: reset has to reload every word at
  // once, so each word is its own register with its own reset constant.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [WORD_W-1:0] RST_VAL = boot_word(gi);

    logic [WORD_W-1:0] r_word;

    assign w_wr_en[gi] = memwrite && (address == ADDR_W'(gi));
    assign w_words[gi] = r_word;

    // Reload boot value on reset, otherwise capture writedata when addressed.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_word <= RST_VAL;
      end else if (w_wr_en[gi]) begin
        r_word <= writedata;
      end
    end
  end

  // Zero-extend the addressed word onto the instruction bus.
  assign w_rd_ext = {{(DATA_W - WORD_W){1'b0}}, w_words[address]};

  // Registered fetch; sampling the pre-edge array gives read-before-write,
  // and readdata holds when memread is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (memread) begin
      readdata <= w_rd_ext;
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// Scoreboard bench for mem_bank: stimulus pushes expected readdata from a
// plain-array model, an independent monitor pops and compares after each edge.
module tb_mem_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [7:0]  address = '0;
  logic [15:0] writedata = '0;
  logic [31:0] readdata;

  mem_bank dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [7:0]  addr;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          txn = 0;

  // Reference model: the memory as a plain array plus the last bus value.
  logic [15:0] model_mem [256];
  logic [31:0] model_rd;
  logic [15:0] boot_tab [17];

  // Immediate-check requests handled by the monitor (kind 1: readdata
  // value, kind 2: scoreboard drained).
  logic        imm_req = 1'b0;
  int          imm_kind = 0;
  logic [31:0] imm_exp = '0;
  logic        mon_stop = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = (i < 17) ? boot_tab[i] : 16'h0000;
    model_rd = 32'h0;
  endtask

  // One clock transaction: drive, predict, push, then cross the edge.
  task automatic do_cycle(input logic rd, input logic wr,
                          input logic [7:0] a, input logic [15:0] wd);
    sb_item_t it;
    logic [31:0] e;
    memread   = rd;
    memwrite  = wr;
    address   = a;
    writedata = wd;
    if (reset) begin
      e = 32'h0;
    end else begin
      e = rd ? {16'h0000, model_mem[a]} : model_rd;
      if (wr) model_mem[a] = wd;
    end
    model_rd = e;
    it.idx  = txn;
    it.addr = a;
    it.exp  = e;
    sb_q.push_back(it);
    $display("txn %0d: rst=%0b rd=%0b wr=%0b addr=%0d wd=%h exp=%h",
             txn, reset, rd, wr, a, wd, e);
    txn++;
    @(posedge clk);
    #2;
  endtask

  task automatic imm_check(input int kind, input logic [31:0] e);
    imm_kind = kind;
    imm_exp  = e;
    imm_req  = 1'b1;
    #1;
    imm_req  = 1'b0;
    #1;
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    sb_item_t it;
    while (!mon_stop) begin
      @(posedge clk or posedge imm_req);
      if (imm_req) begin
        checks++;
        if (imm_kind == 1) begin
          if (readdata !== imm_exp) begin
            errors++;
            $display("FAIL imm_readdata got=%h exp=%h", readdata, imm_exp);
          end else begin
            $display("chk imm_readdata ok val=%h", readdata);
          end
        end else begin
          if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
          end
        end
      end else begin
        #1;
        if (sb_q.size() > 0) begin
          it = sb_q.pop_front();
          checks++;
          if (readdata !== it.exp) begin
            errors++;
            $display("FAIL read txn=%0d addr=%0d got=%h exp=%h",
                     it.idx, it.addr, readdata, it.exp);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    boot_tab = '{16'h0008, 16'h7280, 16'h72C0, 16'h1100, 16'h1152, 16'h994A,
                 16'h1902, 16'h0308, 16'h7380, 16'hBC82, 16'hCCC3, 16'hF004,
                 16'h0C10, 16'hF009, 16'h0C18, 16'hF004, 16'h0001};
    model_reset();

    // Reset state: bus cleared while reset held from time zero.
    #3;
    imm_check(1, 32'h0);
    @(posedge clk);
    #4;
    reset = 1'b0;
    #2;

    // First fetches: one-cycle latency.
    for (int a = 0; a < 4; a++) do_cycle(1'b1, 1'b0, 8'(a), 16'h0);

    // Full address sweep against the boot image.
    for (int a = 0; a < 256; a++) do_cycle(1'b1, 1'b0, 8'(a), 16'h0);

    // Hold when memread is low.
    do_cycle(1'b1, 1'b0, 8'd5, 16'h0);
    do_cycle(1'b0, 1'b0, 8'd9, 16'h0);
    do_cycle(1'b0, 1'b0, 8'd9, 16'h0);

    // Load, then read back; read-before-write on a same-cycle collision.
    do_cycle(1'b0, 1'b1, 8'd200, 16'hABCD);
    do_cycle(1'b1, 1'b0, 8'd200, 16'h0);
    do_cycle(1'b1, 1'b1, 8'd3, 16'h5555);
    do_cycle(1'b1, 1'b0, 8'd3, 16'h0);
    do_cycle(1'b1, 1'b0, 8'd255, 16'h0);
    do_cycle(1'b0, 1'b1, 8'd255, 16'h1234);
    do_cycle(1'b1, 1'b0, 8'd255, 16'h0);

    // Random traffic, biased toward a small window to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 20));
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
               16'($urandom));
    end

    // Make sure the bus is non-zero before the mid-cycle reset.
    do_cycle(1'b1, 1'b0, 8'd0, 16'h0);

    // Reset between edges: bus clears at once, activity during reset ignored.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    imm_check(1, 32'h0);
    do_cycle(1'b1, 1'b1, 8'd200, 16'h7777);
    do_cycle(1'b1, 1'b1, 8'd3, 16'h8888);
    reset = 1'b0;
    #1;

    do_cycle(1'b1, 1'b0, 8'd200, 16'h0);
    do_cycle(1'b1, 1'b0, 8'd3, 16'h0);
    for (int a = 0; a < 256; a++) do_cycle(1'b1, 1'b0, 8'(a), 16'h0);

    memread  = 1'b0;
    memwrite = 1'b0;
    @(posedge clk);
    #3;
    imm_check(2, 32'h0);
    mon_stop = 1'b1;
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
Name: mem_bank

Overview:
Instruction memory bank for the single-cycle/pipelined CPU: 256 words of 16-bit instructions, addressed by an 8-bit PC.
- Fetch port: synchronous read, zero-extended to the 32-bit instruction bus.
- Load port: synchronous write, for program loading and self-test.
- Asynchronous reset restores the default boot program image.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W = 256 words.
- WORD_W, 16, stored instruction width.
- DATA_W, 32, read bus width; WORD_W zero-extended to DATA_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- memread  input  1  read enable.
- memwrite  input  1  write enable (program load).
- address  input  ADDR_W  word address, shared by read and write.
- writedata  input  WORD_W  word to store.
- readdata  output  DATA_W  fetched word, zero-extended.

Behaviour:
Interface (already decided):
- One clock, clk.
- reset is asynchronous and active-high.

Storage:
- 256 x 16-bit register array.

Reset (reset=1, takes effect immediately, independent of clk):
- readdata = 0x00000000.
- Words 0..16 load the boot image, in hex: 0008, 7280, 72C0, 1100, 1152, 994A, 1902, 0308, 7380, BC82, CCC3, F004, 0C10, F009, 0C18, F004, 0001.
- Words 17..255 = 0x0000.
- While reset is held, reads and writes are ignored.
- Reset asserted mid-operation discards any in-flight read or write that cycle.

Read:
- At posedge clk with memread=1: readdata <= {16'h0000, mem[address]}.
- Latency is 1 cycle.
- When memread=0, readdata holds its previous value.

Write:
- At posedge clk with memwrite=1: mem[address] <= writedata.

Simultaneous read and write to the same address:
- Read-before-write: readdata returns the old word.
- The new word is visible from the next read onward.

Addressing:
- The full 8-bit space is valid; no out-of-range condition.
- Address 255 is the last word; no wrap logic is needed.

Other rules:
- No X on readdata after the first reset.
- Contents persist until rewritten or reset.

Decomposition:
Package mem_bank_pkg holds:
- ADDR_W, WORD_W, DATA_W.
- BOOT_LEN = 17.
- Constant array BOOT_IMAGE[0:16] containing the image above.

Structure:
- Single module, no sub-modules.
- Reset-image load is a loop over BOOT_IMAGE, zero-filling the remaining words.

Test Plan:
1. Assert reset, release; memread=1, address 0,1,2,3 on successive cycles -> readdata 0x00000008, 0x00007280, 0x000072C0, 0x00001100, each one cycle after its address.
2. Sweep address 0..255 with memread=1 -> 5:0x0000994A, 11:0x0000F004, 13:0x0000F009, 16:0x00000001, 17..255:0x00000000.
3. Read address 5 (0x0000994A), then memread=0 and address=9 -> readdata stays 0x0000994A.
4. memwrite=1, address 200, writedata 0xABCD, then read 200 -> 0x0000ABCD; same-cycle read+write at address 3 with 0x5555 -> 0x00001100, next read -> 0x00005555.
5. After the writes, assert reset mid-cycle (not on a clock edge) -> readdata immediately 0; reads then return address 200 -> 0x00000000, address 3 -> 0x00001100.
